// File: rtl/apb4_master_bridge.sv
// APB4 initiator: turns one valid/ready command into a single SETUP+ACCESS transfer
// and returns the result on a valid/ready response channel, with a bounded wait on pready.
module apb4_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,  // 8, 16 or 32
  parameter int TIMEOUT_CYCLES = 256  // 0 disables the timeout
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  // The APB address/control/data outputs double as the command holding registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= IDLE;
      to_cnt        <= '0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      paddr         <= '0;
      pprot         <= '0;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      pwdata        <= '0;
      pstrb         <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            paddr       <= req_addr_i;
            pprot       <= req_prot_i;
            pwrite      <= req_write_i;
            pwdata      <= req_write_i ? req_wdata_i : '0;
            pstrb       <= req_write_i ? req_strb_i : '0;
            psel        <= 1'b1;
            to_cnt      <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready beats a simultaneous timeout
          if (pready) begin
            psel          <= 1'b0;
            penable       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= pslverr;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= pwrite ? '0 : prdata;
            state         <= RESP;
          end else if (timeout_hit) begin
            psel          <= 1'b0;
            penable       <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= '0;
            state         <= RESP;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed bench for apb4_master_bridge: the bench plays the APB slave and the requester.
module tb_apb4_master_bridge;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_strb_i = '0;
  logic [2:0]  req_prot_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 pclk = ~pclk;

  apb4_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // One full transfer starting at a negedge in IDLE. waits < 0 means the slave never answers.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb, input int waits,
                      input logic [31:0] rd, input logic err, input int hold,
                      input int exp_acc, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic exp_to);
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    logic        ok;
    logic        hold_ok;
    int          acc;
    exp_wd = wr ? wd : 32'h0;
    exp_st = wr ? strb : 4'h0;
    check({tag, ".req_ready"}, {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
    req_wdata_i = wd; req_strb_i = strb; req_prot_i = 3'b010;
    @(negedge pclk);
    // scramble the request bus: it must be ignored from here on
    req_valid_i = 1'b0; req_write_i = ~wr; req_addr_i = '1;
    req_wdata_i = '1; req_strb_i = '1; req_prot_i = 3'b101;
    ok = psel && !penable && !rsp_valid_o && paddr == addr && pwrite == wr &&
         pwdata == exp_wd && pstrb == exp_st && pprot == 3'b010;
    acc = 0;
    @(negedge pclk);
    while (psel && penable && acc < 40) begin
      acc++;
      ok &= paddr == addr && pwrite == wr && pwdata == exp_wd &&
            pstrb == exp_st && pprot == 3'b010 && !rsp_valid_o;
      pready  = (waits >= 0) && (acc == waits + 1);
      prdata  = rd;
      pslverr = err;
      @(negedge pclk);
    end
    pready = 1'b0; pslverr = 1'b1; prdata = 32'h5A5A5A5A;
    check({tag, ".access_cycles"}, acc, exp_acc);
    check({tag, ".setup_access_stable"}, {31'b0, ok}, 32'd1);
    check({tag, ".psel_penable_off"}, {30'b0, psel, penable}, 32'd0);
    check({tag, ".rsp_valid"}, {31'b0, rsp_valid_o}, 32'd1);
    check({tag, ".rsp_rdata"}, rsp_rdata_o, exp_rdata);
    check({tag, ".rsp_err_to"}, {30'b0, rsp_err_o, rsp_timeout_o}, {30'b0, exp_err, exp_to});
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      req_valid_i = 1'b1; req_addr_i = 32'h0000_0F00;
      @(negedge pclk);
      hold_ok &= rsp_valid_o && rsp_rdata_o == exp_rdata && rsp_err_o == exp_err &&
                 rsp_timeout_o == exp_to && !req_ready_o && !psel;
    end
    if (hold > 0) check({tag, ".rsp_hold_stable"}, {31'b0, hold_ok}, 32'd1);
    pslverr = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge pclk);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    check({tag, ".after_hs"}, {29'b0, rsp_valid_o, req_ready_o, psel}, 32'b010);
  endtask

  initial begin
    #3;
    check("reset.outputs", {26'b0, req_ready_o, rsp_valid_o, psel, penable, rsp_err_o, rsp_timeout_o}, 32'd0);
    check("reset.paddr_pwdata", paddr | pwdata | rsp_rdata_o, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    check("reset.req_ready_low_first", {31'b0, req_ready_o}, 32'd0);
    @(negedge pclk);
    check("reset.req_ready_up", {31'b0, req_ready_o}, 32'd1);

    //    tag        wr    addr   wdata         strb  waits rdata        err  hold acc  exp_rdata    err  to
    xfer("wr0ws",   1'b1, 32'h04, 32'h12345678, 4'hF, 0,    32'hFFFFFFFF, 1'b0, 0,   1,   32'h0,       1'b0, 1'b0);
    xfer("rd3ws",   1'b0, 32'h08, 32'hA5A5A5A5, 4'hF, 3,    32'hDEADBEEF, 1'b0, 0,   4,   32'hDEADBEEF, 1'b0, 1'b0);
    xfer("rdslverr",1'b0, 32'h10, 32'h0,        4'h0, 1,    32'h0BADF00D, 1'b1, 0,   2,   32'h0BADF00D, 1'b1, 1'b0);
    xfer("timeout", 1'b0, 32'h20, 32'h0,        4'h0, -1,   32'hCAFEF00D, 1'b0, 0,   8,   32'h0,       1'b1, 1'b1);
    xfer("rdy8th",  1'b0, 32'h24, 32'h0,        4'h0, 7,    32'h13579BDF, 1'b0, 0,   8,   32'h13579BDF, 1'b0, 1'b0);
    xfer("rsphold", 1'b1, 32'h30, 32'h00FF00FF, 4'h5, 2,    32'h11111111, 1'b0, 5,   3,   32'h0,       1'b0, 1'b0);

    // reset in the middle of ACCESS
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h40; req_wdata_i = 32'h77; req_strb_i = 4'h3;
    @(negedge pclk);
    req_valid_i = 1'b0;
    @(negedge pclk);
    check("midrst.in_access", {30'b0, psel, penable}, 32'b11);
    #2 presetn = 1'b0;
    #1 check("midrst.async_drop", {29'b0, psel, penable, rsp_valid_o}, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("midrst.no_rsp", {30'b0, rsp_valid_o, psel}, 32'd0);
    xfer("postrst", 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h2468ACE0, 1'b0, 0, 1, 32'h2468ACE0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- APB4 initiator that converts a simple valid/ready command/response interface into single APB4 transfers (SETUP then ACCESS phases).
- It is the requester-side counterpart of the team's APB4 register slaves (archinfo, timers, etc.).
- Sits between a CPU/debug/DMA-style request source and the APB4 fabric.
- Handles wait states, captures pslverr, and applies a bounded-wait timeout so a dead slave cannot hang the requester.

Parameters:
ADDR_WIDTH, 32, width of paddr and req_addr_i
DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles waiting for pready; 0 disables the timeout

Ports:
pclk  in  1  APB clock; the single clock of the block
presetn  in  1  asynchronous active-low reset
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted (high only in IDLE)
req_addr_i  in  ADDR_WIDTH  transfer address
req_write_i  in  1  1=write, 0=read
req_wdata_i  in  DATA_WIDTH  write data
req_strb_i  in  DATA_WIDTH/8  write byte strobes
req_prot_i  in  3  protection attributes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err_o  out  1  slave error or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
paddr  out  ADDR_WIDTH  APB address
pprot  out  3  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB write strobes
pready  in  1  APB slave ready
prdata  in  DATA_WIDTH  APB read data
pslverr  in  1  APB slave error

Behaviour:
- Clocking and reset: one clock (pclk); asynchronous active-low reset (presetn).
- Reset values: all outputs 0, FSM = IDLE, timeout counter 0. req_ready_o is 0 during reset and becomes 1 in the first IDLE cycle after reset is released.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1; psel=0, penable=0.
  - On req_valid_i&&req_ready_o, latch addr/write/wdata/strb/prot into holding registers and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0.
  - paddr/pprot/pwrite driven from the holding registers.
  - Writes: pwdata = latched wdata, pstrb = latched strb.
  - Reads: pwdata=0, pstrb=0.
  - Always go to ACCESS next.
- ACCESS:
  - psel=1, penable=1; all address, control and data outputs held identical to SETUP.
  - On pready=1:
    - capture rsp_err_o=pslverr;
    - capture rsp_rdata_o = prdata for reads, 0 for writes;
    - rsp_timeout_o=0;
    - go to RESP.
  - Timeout:
    - The counter increments on every ACCESS cycle with pready=0.
    - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 while pready is still 0, go to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - psel/penable are deasserted on leaving ACCESS.
  - The counter clears on entering SETUP.
  - pready seen on the same cycle as the timeout condition wins (normal completion).
- RESP:
  - psel=0, penable=0; rsp_valid_o=1.
  - rsp_* held stable until rsp_ready_i.
  - On rsp_valid_o&&rsp_ready_i, go to IDLE and drop rsp_valid_o.
- Throughput: minimum 4 cycles per transfer (IDLE→SETUP→ACCESS→RESP→IDLE) with zero wait states and rsp_ready_i tied high.
- Latency: from the accept edge to rsp_valid_o is 2+N cycles, where N = wait states.
- Input qualification:
  - req_* inputs are ignored outside IDLE.
  - pready, prdata and pslverr are ignored outside ACCESS.
- Reset mid-transfer: psel/penable drop immediately (asynchronously); no response is produced for the aborted command.
- No combinational path from rsp_ready_i or pready to req_ready_o; req_ready_o is a decode of the registered state.

Test Plan:
- Write 0x12345678, strb 0xF, to 0x04; slave has 0 wait states → psel rises cycle 1, penable cycle 2; rsp_valid_o cycle 3 with rsp_err_o=0, rsp_rdata_o=0; pwdata/paddr stable across SETUP+ACCESS.
- Read 0x08 with 3 wait states, slave returns 0xDEADBEEF → penable high for 4 cycles; rsp_rdata_o=0xDEADBEEF; pstrb=0 and pwdata=0 throughout.
- Read with pslverr=1 at pready → rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=prdata.
- TIMEOUT_CYCLES=8, pready held 0 → exactly 8 ACCESS cycles, then psel=0; rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. With pready rising on the 8th cycle → normal completion, no timeout.
- rsp_ready_i held low 5 cycles in RESP → rsp_* stable; req_ready_o=0; a new req_valid_i is not accepted until 1 cycle after the response handshake.
- presetn asserted during ACCESS → psel/penable/rsp_valid_o=0 immediately; after release, req_ready_o=1 and the next transfer completes normally.
